// File: rtl/sub_deparser_pkg.sv
// rtl/sub_deparser_pkg.sv - shared types and PHV layout helpers for the sequential deparser extractor
// Contents: field type codes, FSM state enum, container start-position functions.
package sub_deparser_pkg;

    typedef enum logic [1:0] {
        T_BAD = 2'b00,
        T_2B  = 2'b01,
        T_4B  = 2'b10,
        T_6B  = 2'b11
    } field_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    // PHV layout, low to high: metadata, 2B containers, 4B containers, 6B containers.
    function automatic int start_2b(input int meta_w);
        return meta_w;
    endfunction

    function automatic int start_4b(input int meta_w, input int num_2b);
        return meta_w + 16 * num_2b;
    endfunction

    function automatic int start_6b(input int meta_w, input int num_2b, input int num_4b);
        return meta_w + 16 * num_2b + 32 * num_4b;
    endfunction

    function automatic int pkt_vec_width(input int meta_w, input int num_2b,
                                         input int num_4b, input int num_6b);
        return meta_w + 16 * num_2b + 32 * num_4b + 48 * num_6b;
    endfunction

endpackage

// File: rtl/sub_deparser_seq_if.sv
// rtl/sub_deparser_seq_if.sv - PHV input and field output streams of the sequential extractor
// master: PHV producer / field consumer. slave: the extractor.
//   phv_in_valid/phv_in_ready/phv_in/parse_acts_in : PHV + packed action list
//   val_out_valid/val_out_ready/val_out/val_out_type/val_out_last : field beats
//   phv_done : one-cycle pulse when a PHV is retired
interface sub_deparser_seq_if #(
    parameter int C_PKT_VEC_WIDTH = 2816,
    parameter int C_NUM_ACTS      = 10,
    parameter int C_PARSE_ACT_LEN = 9
);
    logic                                  phv_in_valid;
    logic                                  phv_in_ready;
    logic [C_PKT_VEC_WIDTH-1:0]            phv_in;
    logic [C_NUM_ACTS*C_PARSE_ACT_LEN-1:0] parse_acts_in;
    logic                                  val_out_valid;
    logic                                  val_out_ready;
    logic [47:0]                           val_out;
    logic [1:0]                            val_out_type;
    logic                                  val_out_last;
    logic                                  phv_done;

    modport master (
        output phv_in_valid, phv_in, parse_acts_in, val_out_ready,
        input  phv_in_ready, val_out_valid, val_out, val_out_type, val_out_last, phv_done
    );

    modport slave (
        input  phv_in_valid, phv_in, parse_acts_in, val_out_ready,
        output phv_in_ready, val_out_valid, val_out, val_out_type, val_out_last, phv_done
    );
endinterface

// File: rtl/deparser_field_mux.sv
// rtl/deparser_field_mux.sv - combinational selection of one PHV container for one parse action
// Ports:
//   act_i   : parse action [8:7] type, [6:1] container index, [0] valid
//   phv_i   : full PHV vector
//   value_o : selected container, right-aligned, zero-extended to 48 bits
//   type_o  : decoded type code (T_BAD for any unsupported encoding)
//   oor_o   : bad type or index beyond the container count for its type
module deparser_field_mux
    import sub_deparser_pkg::*;
#(
    parameter int C_META_W        = 256,
    parameter int C_NUM_2B        = 8,
    parameter int C_NUM_4B        = 64,
    parameter int C_NUM_6B        = 8,
    parameter int C_PARSE_ACT_LEN = 9,
    parameter int C_PKT_VEC_WIDTH = pkt_vec_width(C_META_W, C_NUM_2B, C_NUM_4B, C_NUM_6B)
) (
    input  logic [C_PARSE_ACT_LEN-1:0] act_i,
    input  logic [C_PKT_VEC_WIDTH-1:0] phv_i,
    output logic [47:0]                value_o,
    output logic [1:0]                 type_o,
    output logic                       oor_o
);
    localparam int B2 = start_2b(C_META_W);
    localparam int B4 = start_4b(C_META_W, C_NUM_2B);
    localparam int B6 = start_6b(C_META_W, C_NUM_2B, C_NUM_4B);

    logic [5:0] cidx;
    logic       unused_meta;

    assign cidx        = act_i[6:1];
    // Metadata is carried in the PHV but never extracted here.
    assign unused_meta = ^phv_i[C_META_W-1:0];

    // Each type is a loop of constant-offset compares, so an index past the
    // container count simply matches nothing and the value stays zero.
    always_comb begin
        value_o = '0;
        type_o  = T_BAD;
        oor_o   = 1'b1;
        case ({act_i[8:7], act_i[0]})
            3'b011: begin
                type_o = T_2B;
                for (int i = 0; i < C_NUM_2B; i++) begin
                    if (int'(cidx) == i) begin
                        value_o = {32'h0, phv_i[B2 + 16*i +: 16]};
                        oor_o   = 1'b0;
                    end
                end
            end
            3'b101: begin
                type_o = T_4B;
                for (int i = 0; i < C_NUM_4B; i++) begin
                    if (int'(cidx) == i) begin
                        value_o = {16'h0, phv_i[B4 + 32*i +: 32]};
                        oor_o   = 1'b0;
                    end
                end
            end
            3'b111: begin
                type_o = T_6B;
                for (int i = 0; i < C_NUM_6B; i++) begin
                    if (int'(cidx) == i) begin
                        value_o = phv_i[B6 + 48*i +: 48];
                        oor_o   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/sub_deparser_seq.sv
// rtl/sub_deparser_seq.sv - self-sequenced PHV field extractor emitting one beat per valid parse action
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset
//   bus          : sub_deparser_seq_if.slave (PHV in, field beats out, phv_done)
//   oor_err, oor_cnt : present only with SUB_DEPARSER_OOR_CHK_EN; flag with the beat and
//                      16-bit saturating count of out-of-range or bad-type beats
module sub_deparser_seq
    import sub_deparser_pkg::*;
#(
    parameter int C_META_W        = 256,
    parameter int C_NUM_2B        = 8,
    parameter int C_NUM_4B        = 64,
    parameter int C_NUM_6B        = 8,
    parameter int C_PARSE_ACT_LEN = 9,
    parameter int C_NUM_ACTS      = 10,
    localparam int C_PKT_VEC_WIDTH = pkt_vec_width(C_META_W, C_NUM_2B, C_NUM_4B, C_NUM_6B)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    sub_deparser_seq_if.slave    bus
`ifdef SUB_DEPARSER_OOR_CHK_EN
    ,
    output logic                 oor_err,
    output logic [15:0]          oor_cnt
`endif
);
    localparam int IDX_W  = $clog2(C_NUM_ACTS + 1);
    localparam int ACTS_W = C_NUM_ACTS * C_PARSE_ACT_LEN;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [C_PKT_VEC_WIDTH-1:0] phv_q, phv_d;
    logic [ACTS_W-1:0]          acts_q, acts_d;
    logic                       ready_q, ready_d;
    logic                       valid_q, valid_d;
    logic [47:0]                value_q, value_d;
    logic [1:0]                 type_q, type_d;
    logic                       last_q, last_d;
    logic                       done_q, done_d;
    logic                       oor_err_q, oor_err_d;
`ifdef SUB_DEPARSER_OOR_CHK_EN
    logic [15:0]                oor_cnt_q, oor_cnt_d;
`endif

    logic [C_PARSE_ACT_LEN-1:0] cur_act;
    logic                       more_valid;
    logic                       out_free;
    logic [47:0]                mux_value;
    logic [1:0]                 mux_type;
    logic                       mux_oor;

    // Output register can take a new beat when empty or being drained this cycle.
    assign out_free = ~valid_q | bus.val_out_ready;

    // Constant-index select so idx = C_NUM_ACTS in DRAIN never forms an out-of-range slice.
    always_comb begin
        cur_act    = '0;
        more_valid = 1'b0;
        for (int k = 0; k < C_NUM_ACTS; k++) begin
            if (int'(idx_q) == k) cur_act = acts_q[k*C_PARSE_ACT_LEN +: C_PARSE_ACT_LEN];
            if (k > int'(idx_q) && acts_q[k*C_PARSE_ACT_LEN]) more_valid = 1'b1;
        end
    end

    deparser_field_mux #(
        .C_META_W        (C_META_W),
        .C_NUM_2B        (C_NUM_2B),
        .C_NUM_4B        (C_NUM_4B),
        .C_NUM_6B        (C_NUM_6B),
        .C_PARSE_ACT_LEN (C_PARSE_ACT_LEN)
    ) u_field_mux (
        .act_i   (cur_act),
        .phv_i   (phv_q),
        .value_o (mux_value),
        .type_o  (mux_type),
        .oor_o   (mux_oor)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phv_d     = phv_q;
        acts_d    = acts_q;
        valid_d   = valid_q;
        value_d   = value_q;
        type_d    = type_q;
        last_d    = last_q;
        oor_err_d = oor_err_q;
        done_d    = 1'b0;
`ifdef SUB_DEPARSER_OOR_CHK_EN
        oor_cnt_d = oor_cnt_q;
`endif

        // Accepted beat leaves the register clean unless a new one is loaded below.
        if (valid_q && bus.val_out_ready) begin
            valid_d   = 1'b0;
            value_d   = '0;
            type_d    = T_BAD;
            last_d    = 1'b0;
            oor_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ready_q && bus.phv_in_valid) begin
                    phv_d   = bus.phv_in;
                    acts_d  = bus.parse_acts_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_free) begin
                    if (cur_act[0]) begin
                        valid_d   = 1'b1;
                        value_d   = mux_value;
                        type_d    = mux_type;
                        last_d    = ~more_valid;
                        oor_err_d = mux_oor;
`ifdef SUB_DEPARSER_OOR_CHK_EN
                        if (mux_oor && oor_cnt_q != 16'hFFFF) oor_cnt_d = oor_cnt_q + 16'd1;
`endif
                    end
                    if (idx_q == IDX_W'(C_NUM_ACTS - 1)) state_d = DRAIN;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so the input stays closed while reset is asserted.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            phv_q     <= '0;
            acts_q    <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            value_q   <= '0;
            type_q    <= T_BAD;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            oor_err_q <= 1'b0;
`ifdef SUB_DEPARSER_OOR_CHK_EN
            oor_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phv_q     <= phv_d;
            acts_q    <= acts_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            value_q   <= value_d;
            type_q    <= type_d;
            last_q    <= last_d;
            done_q    <= done_d;
            oor_err_q <= oor_err_d;
`ifdef SUB_DEPARSER_OOR_CHK_EN
            oor_cnt_q <= oor_cnt_d;
`endif
        end
    end

    assign bus.phv_in_ready  = ready_q;
    assign bus.val_out_valid = valid_q;
    assign bus.val_out       = value_q;
    assign bus.val_out_type  = type_q;
    assign bus.val_out_last  = last_q;
    assign bus.phv_done      = done_q;

`ifdef SUB_DEPARSER_OOR_CHK_EN
    assign oor_err = oor_err_q;
    assign oor_cnt = oor_cnt_q;
`else
    logic unused_oor;
    assign unused_oor = oor_err_q;
`endif
endmodule

// File: tb/tb_sub_deparser_seq.sv
// tb/tb_sub_deparser_seq.sv - scoreboard bench for sub_deparser_seq
module tb_sub_deparser_seq;
    import sub_deparser_pkg::*;

    localparam int N  = 10;
    localparam int L  = 9;
    localparam int W  = 256 + 16*8 + 32*64 + 48*8;
    localparam int B2 = 256;
    localparam int B4 = 384;
    localparam int B6 = 2432;

    typedef struct packed {
        logic [47:0] v;
        logic [1:0]  t;
        logic        l;
        logic        o;
    } beat_t;

    logic  clk = 1'b0;
    logic  aresetn = 1'b0;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    dones_seen = 0;
    beat_t exp_q[$];
    beat_t held;
    logic  hold_v = 1'b0;
    logic  in_flight = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_deparser_seq_if #(.C_PKT_VEC_WIDTH(W), .C_NUM_ACTS(N), .C_PARSE_ACT_LEN(L)) bus ();

`ifdef SUB_DEPARSER_OOR_CHK_EN
    logic        oor_err;
    logic [15:0] oor_cnt;
`endif

    sub_deparser_seq dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
`ifdef SUB_DEPARSER_OOR_CHK_EN
        ,
        .oor_err (oor_err),
        .oor_cnt (oor_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability and input closure.
    always @(negedge clk) begin
        beat_t e;
        if (!aresetn) begin
            hold_v    = 1'b0;
            in_flight = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", bus.val_out_valid, 1);
                check("stall_data", {bus.val_out, bus.val_out_type, bus.val_out_last},
                      {held.v, held.t, held.l});
            end
            if (in_flight) begin
                if (bus.phv_done) in_flight = 1'b0;
                else check("busy_ready_low", bus.phv_in_ready, 0);
            end
            if (bus.phv_done) dones_seen++;
            if (bus.phv_in_valid && bus.phv_in_ready) in_flight = 1'b1;
            if (bus.val_out_valid && bus.val_out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_value", bus.val_out, e.v);
                    check("beat_type", bus.val_out_type, e.t);
                    check("beat_last", bus.val_out_last, e.l);
`ifdef SUB_DEPARSER_OOR_CHK_EN
                    check("beat_oor_err", oor_err, e.o);
`endif
                end
                beats_seen++;
                hold_v = 1'b0;
            end else if (bus.val_out_valid) begin
                hold_v = 1'b1;
                held.v = bus.val_out;
                held.t = bus.val_out_type;
                held.l = bus.val_out_last;
                held.o = 1'b0;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    function automatic logic [W-1:0] base_phv();
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < W/32; i++) p[i*32 +: 32] = 32'h5A5A_0000 + 32'(i);
        return p;
    endfunction

    function automatic logic [W-1:0] phv_case1();
        logic [W-1:0] p;
        p = base_phv();
        for (int k = 0; k < N; k++) p[B4 + 32*k +: 32] = 32'hA000_0000 + 32'(k);
        return p;
    endfunction

    function automatic logic [N*L-1:0] acts_case1();
        logic [N*L-1:0] a;
        a = '0;
        for (int k = 0; k < N; k++) a[k*L +: L] = {2'b10, 6'(k), 1'b1};
        return a;
    endfunction

    function automatic void push_case1();
        for (int k = 0; k < N; k++)
            exp_q.push_back('{v: {16'h0, 32'hA000_0000 + 32'(k)}, t: 2'b10, l: (k == N-1), o: 1'b0});
    endfunction

    task automatic send(input logic [W-1:0] phv, input logic [N*L-1:0] acts, output int acc);
        int t;
        bus.phv_in        = phv;
        bus.parse_acts_in = acts;
        bus.phv_in_valid  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.phv_in_ready && t < 100);
        check("accept_in_time", t < 100, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.phv_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int acc, input int lat);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.phv_done && t < 200);
        check("done_in_time", t < 200, 1);
        if (lat >= 0) check("done_latency", cyc - acc, lat);
        check("done_output_clear", !bus.val_out_valid || bus.val_out_ready, 1);
        check("ready_at_done", bus.phv_in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, b0, d0, t;
        logic [W-1:0] p;
        logic [N*L-1:0] a;

        bus.phv_in_valid  = 1'b0;
        bus.phv_in        = '0;
        bus.parse_acts_in = '0;
        bus.val_out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_valid", bus.val_out_valid, 0);
        check("rst_ready", bus.phv_in_ready, 0);
        check("rst_done", bus.phv_done, 0);
        check("rst_data", {bus.val_out, bus.val_out_type, bus.val_out_last}, 0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        bus.val_out_ready = 1'b1;

        // Case 1: ten 4B beats back to back
        b0 = beats_seen; d0 = dones_seen;
        push_case1();
        send(phv_case1(), acts_case1(), acc);
        wait_done(acc, N + 1);
        check("c1_beats", beats_seen - b0, N);
        check("c1_dones", dones_seen - d0, 1);
        check("c1_sb_empty", exp_q.size(), 0);

        // Case 2: mixed 2B / skipped / 6B
        p = base_phv();
        p[B2 + 16*3 +: 16] = 16'hBEEF;
        p[B6 + 48*7 +: 48] = 48'h1122_3344_5566;
        a = '0;
        a[0*L +: L] = {2'b01, 6'd3, 1'b1};
        a[1*L +: L] = {2'b10, 6'd5, 1'b0};
        a[2*L +: L] = {2'b11, 6'd7, 1'b1};
        exp_q.push_back('{v: 48'h0000_0000_BEEF, t: 2'b01, l: 1'b0, o: 1'b0});
        exp_q.push_back('{v: 48'h1122_3344_5566, t: 2'b11, l: 1'b1, o: 1'b0});
        b0 = beats_seen;
        send(p, a, acc);
        wait_done(acc, N + 1);
        check("c2_beats", beats_seen - b0, 2);
        check("c2_sb_empty", exp_q.size(), 0);

        // Case 3: case 1 under backpressure
        b0 = beats_seen; d0 = dones_seen;
        push_case1();
        fork
            begin
                send(phv_case1(), acts_case1(), acc);
                wait_done(acc, -1);
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    bus.val_out_ready = (i >= 8 && i < 13) ? 1'b0 : (i % 2 == 0);
                    @(posedge clk);
                    #1;
                end
                bus.val_out_ready = 1'b1;
            end
        join
        check("c3_beats", beats_seen - b0, N);
        check("c3_dones", dones_seen - d0, 1);
        check("c3_sb_empty", exp_q.size(), 0);

        // Case 4: no valid actions
        b0 = beats_seen;
        send(phv_case1(), '0, acc);
        wait_done(acc, N + 1);
        check("c4_beats", beats_seen - b0, 0);

        // Case 5: reset during beat 4, then a clean PHV
        b0 = beats_seen;
        push_case1();
        send(phv_case1(), acts_case1(), acc);
        t = 0;
        while (beats_seen - b0 < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("c5_three_beats", beats_seen - b0, 3);
        @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        check("c5_rst_valid", bus.val_out_valid, 0);
        check("c5_rst_data", {bus.val_out, bus.val_out_type, bus.val_out_last}, 0);
        check("c5_rst_ready", bus.phv_in_ready, 0);
        exp_q.delete();
        d0 = dones_seen;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        check("c5_no_done", dones_seen - d0, 0);
`ifdef SUB_DEPARSER_OOR_CHK_EN
        check("c5_oor_cnt_rst", oor_cnt, 0);
`endif
        b0 = beats_seen;
        push_case1();
        send(phv_case1(), acts_case1(), acc);
        wait_done(acc, N + 1);
        check("c5_beats", beats_seen - b0, N);
        check("c5_sb_empty", exp_q.size(), 0);

        // Out-of-range indices and bad type
        a = '0;
        a[0*L +: L] = {2'b01, 6'd9, 1'b1};
        a[1*L +: L] = {2'b00, 6'd5, 1'b1};
        a[2*L +: L] = {2'b11, 6'd8, 1'b1};
        a[3*L +: L] = {2'b10, 6'd63, 1'b1};
        exp_q.push_back('{v: 48'h0, t: 2'b01, l: 1'b0, o: 1'b1});
        exp_q.push_back('{v: 48'h0, t: 2'b00, l: 1'b0, o: 1'b1});
        exp_q.push_back('{v: 48'h0, t: 2'b11, l: 1'b0, o: 1'b1});
        exp_q.push_back('{v: 48'h0000_5A5A_004B, t: 2'b10, l: 1'b1, o: 1'b0});
        b0 = beats_seen;
        send(base_phv(), a, acc);
        wait_done(acc, N + 1);
        check("oor_beats", beats_seen - b0, 4);
        check("oor_sb_empty", exp_q.size(), 0);
`ifdef SUB_DEPARSER_OOR_CHK_EN
        check("oor_cnt", oor_cnt, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
